// File: rtl/prg_load_arbiter_if.sv
// Bus bundle for the program-load arbiter: fetch port, UART byte stream,
// program RAM port A and session status.
interface prg_load_arbiter_if;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [13:0] mem_addra;
  logic [31:0] mem_dina;
  logic        mem_wea;
  logic [31:0] mem_douta;
  logic        cpu_hold;
  logic        load_done;
  logic [14:0] words_loaded;

  modport slave (
    input  cpu_addr, load_start, rx_valid, rx_byte, mem_douta,
    output cpu_instr, rx_ready, mem_addra, mem_dina, mem_wea,
           cpu_hold, load_done, words_loaded
  );

  modport master (
    output cpu_addr, load_start, rx_valid, rx_byte, mem_douta,
    input  cpu_instr, rx_ready, mem_addra, mem_dina, mem_wea,
           cpu_hold, load_done, words_loaded
  );
endinterface

// File: rtl/prg_load_arbiter.sv
// Shares program RAM port A between instruction fetch and a UART loader that
// packs little-endian bytes into 32-bit words while the CPU is held in reset.
module prg_load_arbiter #(
  parameter int LOAD_WORDS   = 16384,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  prg_load_arbiter_if.slave  bus
);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, COLLECT, WRITE, FINISH} state_t;

  state_t        state, state_nxt;
  logic [13:0]   word_ptr;
  logic [1:0]    byte_idx;
  logic [IW-1:0] idle;
  logic [14:0]   words_loaded;
  logic [31:0]   asm_word;
  logic          accept, idle_expired, last_word;

  assign idle_expired      = (idle == IW'(IDLE_TIMEOUT - 1));
  assign last_word         = (words_loaded == 15'(LOAD_WORDS - 1));
  assign bus.mem_dina      = asm_word;
  assign bus.words_loaded  = words_loaded;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Fetch owns the RAM only in RUN; every other state points it at word_ptr.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.rx_ready  = 1'b0;
    bus.mem_wea   = 1'b0;
    bus.load_done = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.cpu_instr = 32'h0;
    bus.mem_addra = word_ptr;
    case (state)
      RUN: begin
        bus.cpu_hold  = 1'b0;
        bus.cpu_instr = bus.mem_douta;
        bus.mem_addra = bus.cpu_addr;
        if (bus.load_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        bus.rx_ready = 1'b1;
        accept       = bus.rx_valid;
        if (accept && byte_idx == 2'd3) state_nxt = WRITE;
        else if (!accept && idle_expired) state_nxt = FINISH;
      end
      WRITE: begin
        bus.mem_wea = 1'b1;
        state_nxt   = last_word ? FINISH : COLLECT;
      end
      FINISH: begin
        bus.load_done = 1'b1;
        state_nxt     = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_ptr     <= '0;
      byte_idx     <= '0;
      idle         <= '0;
      words_loaded <= '0;
      asm_word     <= '0;
    end else begin
      case (state)
        RUN: if (bus.load_start) begin
          word_ptr     <= '0;
          byte_idx     <= '0;
          idle         <= '0;
          words_loaded <= '0;
          asm_word     <= '0;
        end
        COLLECT: begin
          if (accept) begin
            asm_word[{byte_idx, 3'b000} +: 8] <= bus.rx_byte;
            byte_idx <= byte_idx + 2'd1;
            idle     <= '0;
          end else if (idle_expired) begin
            // timeout drops any partially assembled word
            byte_idx <= '0;
            asm_word <= '0;
            idle     <= '0;
          end else begin
            idle <= idle + IW'(1);
          end
        end
        WRITE: begin
          word_ptr     <= word_ptr + 14'd1;
          words_loaded <= words_loaded + 15'd1;
          byte_idx     <= '0;
          asm_word     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prg_load_arbiter.sv
// Randomized self-checking bench for prg_load_arbiter with a behavioural RAM
// and a session model derived from byte counts.
module tb_prg_load_arbiter;
  localparam int LW = 4;
  localparam int IT = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prg_load_arbiter_if ifc();
  prg_load_arbiter #(.LOAD_WORDS(LW), .IDLE_TIMEOUT(IT)) dut (
    .clock(clock), .reset(reset), .bus(ifc)
  );

  logic [31:0] ram [0:16383];
  logic        tb_we;
  logic [13:0] tb_wa;
  logic [31:0] tb_wd;

  always @(posedge clock) begin
    if (ifc.mem_wea) ram[ifc.mem_addra] <= ifc.mem_dina;
    else if (tb_we)  ram[tb_wa] <= tb_wd;
    ifc.mem_douta <= ram[ifc.mem_addra];
  end

  int cyc = 0, acc_cnt = 0, done_cnt = 0, last_acc = 0, done_at = 0;
  logic [45:0] wr_log[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && ifc.rx_valid && ifc.rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (ifc.load_done) begin
      done_cnt <= done_cnt + 1;
      done_at  <= cyc;
    end
    if (ifc.mem_wea) wr_log.push_back({ifc.mem_addra, ifc.mem_dina});
  end

  int tests = 0, fails = 0;
  logic [7:0] stim[$];

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic start_load();
    @(negedge clock); ifc.load_start = 1'b1;
    @(negedge clock); ifc.load_start = 1'b0;
  endtask

  // Feed stim[first +: cnt]; optional idle gap before each byte and an
  // optional load_start pulse alongside byte ls_at.
  task automatic feed(input int first, input int cnt, input int max_gap, input int ls_at);
    bit got;
    for (int k = first; k < first + cnt; k++) begin
      ifc.rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
      ifc.rx_byte  = stim[k];
      ifc.rx_valid = 1'b1;
      if (k == ls_at) ifc.load_start = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        if (ifc.rx_ready) got = 1'b1;
        @(negedge clock);
        ifc.load_start = 1'b0;
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL feed_accept: byte %0d not accepted, required acceptance within 8 cycles", k);
        ifc.rx_valid = 1'b0;
        return;
      end
    end
    ifc.rx_valid = 1'b0;
  endtask

  task automatic run_session(input int n, input int max_gap, input int ls_at);
    int w0, a0, d0, fed, words, acc_exp, lat;
    bit seen;
    logic [45:0] e;
    logic [31:0] exp_w;
    w0 = wr_log.size(); a0 = acc_cnt; d0 = done_cnt;
    fed = (n < 4 * LW) ? n : 4 * LW;
    acc_exp = fed;
    words = fed / 4;
    start_load();
    tests++;
    if (ifc.cpu_hold !== 1'b1 || ifc.words_loaded !== 15'd0) begin
      fails++;
      $display("FAIL session_start: hold=%b words=%0d, required hold=1 words=0", ifc.cpu_hold, ifc.words_loaded);
    end
    feed(0, fed, max_gap, ls_at);
    if (n > fed) begin
      ifc.rx_byte = stim[fed]; ifc.rx_valid = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 4 * IT + 20 && !seen; t++) begin
      if (ifc.load_done) seen = 1'b1;
      else @(negedge clock);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL load_done_wait: no load_done within %0d cycles (n=%0d)", 4 * IT + 20, n);
    end else begin
      tests++;
      if (ifc.cpu_hold !== 1'b1) begin
        fails++; $display("FAIL hold_in_finish: got %b required 1", ifc.cpu_hold);
      end
      @(negedge clock);
      tests++;
      if (ifc.cpu_hold !== 1'b0 || ifc.load_done !== 1'b0 || ifc.rx_ready !== 1'b0) begin
        fails++;
        $display("FAIL after_finish: hold=%b done=%b ready=%b, required 0 0 0",
                 ifc.cpu_hold, ifc.load_done, ifc.rx_ready);
      end
    end
    repeat (3) @(negedge clock);
    ifc.rx_valid = 1'b0;
    @(negedge clock);
    tests++;
    if (acc_cnt - a0 != acc_exp) begin
      fails++; $display("FAIL accepted_bytes: got %0d required %0d", acc_cnt - a0, acc_exp);
    end
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++; $display("FAIL done_pulses: got %0d required 1", done_cnt - d0);
    end
    tests++;
    if (ifc.words_loaded !== 15'(words)) begin
      fails++; $display("FAIL words_loaded: got %0d required %0d", ifc.words_loaded, words);
    end
    tests++;
    if (wr_log.size() - w0 != words) begin
      fails++; $display("FAIL write_count: got %0d required %0d", wr_log.size() - w0, words);
    end else begin
      for (int i = 0; i < words; i++) begin
        e = wr_log[w0 + i];
        exp_w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
        tests++;
        if (e[45:32] !== 14'(i) || e[31:0] !== exp_w) begin
          fails++;
          $display("FAIL write_%0d: got addr %0d data %h required addr %0d data %h",
                   i, e[45:32], e[31:0], i, exp_w);
        end
      end
    end
    if (n > 0 && seen) begin
      lat = (fed == 4 * LW) ? 2 : ((fed % 4 == 0) ? IT + 2 : IT + 1);
      tests++;
      if (done_at - last_acc != lat) begin
        fails++; $display("FAIL end_latency: got %0d cycles required %0d", done_at - last_acc, lat);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.load_start = 1'b1; ifc.rx_valid = 1'b1; ifc.rx_byte = 8'hA5;
    repeat (3) @(negedge clock);
    tests++;
    if (ifc.cpu_hold !== 1'b0 || ifc.rx_ready !== 1'b0 || ifc.mem_wea !== 1'b0 ||
        ifc.load_done !== 1'b0 || ifc.words_loaded !== 15'd0) begin
      fails++;
      $display("FAIL reset_state: hold=%b ready=%b wea=%b done=%b words=%0d, required all 0",
               ifc.cpu_hold, ifc.rx_ready, ifc.mem_wea, ifc.load_done, ifc.words_loaded);
    end
    ifc.load_start = 1'b0; ifc.rx_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_run_read();
    logic [13:0] a [4];
    logic [31:0] d [4];
    a[0] = 14'd5; d[0] = 32'h2402000A;
    for (int i = 1; i < 4; i++) begin
      a[i] = 14'(100 + i * 7); d[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      tb_we = 1'b1; tb_wa = a[i]; tb_wd = d[i];
      @(negedge clock);
    end
    tb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.cpu_addr = a[i];
      @(negedge clock);
      tests++;
      if (ifc.cpu_instr !== d[i] || ifc.cpu_hold !== 1'b0) begin
        fails++;
        $display("FAIL run_read_%0d: instr=%h hold=%b required instr=%h hold=0",
                 a[i], ifc.cpu_instr, ifc.cpu_hold, d[i]);
      end
    end
  endtask

  task automatic test_single_word();
    stim = '{8'h0A, 8'h00, 8'h02, 8'h24};
    run_session(4, 0, -1);
    ifc.cpu_addr = 14'd0;
    @(negedge clock);
    tests++;
    if (ifc.cpu_instr !== 32'h2402000A) begin
      fails++; $display("FAIL single_word_fetch: got %h required 2402000a", ifc.cpu_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    fill_random(20);
    run_session(20, 0, -1);
    for (int i = 0; i < LW; i++) begin
      ifc.cpu_addr = 14'(i);
      @(negedge clock);
      exp_w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
      tests++;
      if (ifc.cpu_instr !== exp_w) begin
        fails++; $display("FAIL b2b_fetch_%0d: got %h required %h", i, ifc.cpu_instr, exp_w);
      end
    end
  endtask

  task automatic test_timeout_partial();
    fill_random(6);
    run_session(6, 0, -1);
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    w0 = wr_log.size(); d0 = done_cnt;
    fill_random(2);
    start_load();
    feed(0, 2, 0, -1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if (ifc.cpu_hold !== 1'b0 || ifc.rx_ready !== 1'b0 || ifc.words_loaded !== 15'd0) begin
      fails++;
      $display("FAIL reset_mid: hold=%b ready=%b words=%0d, required 0 0 0",
               ifc.cpu_hold, ifc.rx_ready, ifc.words_loaded);
    end
    repeat (IT + 4) @(negedge clock);
    tests++;
    if (wr_log.size() != w0 || done_cnt != d0) begin
      fails++;
      $display("FAIL reset_mid_quiet: writes=%0d done=%0d, required 0 0", wr_log.size() - w0, done_cnt - d0);
    end
  endtask

  task automatic test_load_start_ignored();
    fill_random(10);
    run_session(10, 1, 2);
    fill_random(7);
    run_session(7, 0, 5);
  endtask

  task automatic test_random_sessions();
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 22);
      fill_random(n);
      run_session(n, 3, (n > 0) ? int'($urandom_range(0, n)) : -1);
    end
  endtask

  initial begin
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    ifc.cpu_addr = '0; ifc.load_start = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_byte = '0;
    reset = 1'b1;
    test_reset();
    test_run_read();
    test_single_word();
    test_back_to_back();
    test_timeout_partial();
    test_reset_mid();
    test_load_start_ignored();
    test_random_sessions();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prg_load_arbiter.md
PRG_LOAD_ARBITER -- requirements
Module: prg_load_arbiter

Interface
REQ-001 Parameter LOAD_WORDS, default 16384, is the maximum words written per load session (1..16384).
REQ-002 Parameter IDLE_TIMEOUT, default 1000000, is the number of idle cycles in COLLECT that ends a session.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 cpu_addr  in  14  word address from the fetch unit.
REQ-006 cpu_instr  out  32  instruction returned to the fetch unit.
REQ-007 load_start  in  1  single-cycle request to start a program load.
REQ-008 rx_valid  in  1  UART byte available.
REQ-009 rx_byte  in  8  UART byte.
REQ-010 rx_ready  out  1  byte accepted when rx_valid and rx_ready are both high.
REQ-011 mem_addra  out  14  program RAM address.
REQ-012 mem_dina  out  32  program RAM write data.
REQ-013 mem_wea  out  1  program RAM write enable.
REQ-014 mem_douta  in  32  program RAM read data (1-cycle read latency).
REQ-015 cpu_hold  out  1  CPU held in reset while high.
REQ-016 load_done  out  1  one-cycle pulse at the end of a session.
REQ-017 words_loaded  out  15  words written in the last or current session.

Function
REQ-018 The FSM SHALL have the states RUN, COLLECT, WRITE and FINISH.
REQ-019 RUN behaviour: mem_addra=cpu_addr, cpu_instr=mem_douta, mem_wea=0, rx_ready=0, cpu_hold=0.
REQ-020 Outside RUN: cpu_instr=0, cpu_hold=1, mem_addra=word_ptr.
REQ-021 load_start in RUN SHALL move to COLLECT next cycle and clear word_ptr, byte_idx, words_loaded and the idle counter.
REQ-022 load_start in any state other than RUN SHALL be ignored.
REQ-023 rx_ready SHALL be 1 only in COLLECT.
REQ-024 Each accepted byte SHALL be placed little-endian: byte_idx 0 goes to bits [7:0] and byte_idx 3 goes to bits [31:24].
REQ-025 Each accepted byte SHALL increment byte_idx modulo 4 and clear the idle counter.
REQ-026 Accepting the 4th byte (byte_idx=3) SHALL move COLLECT to WRITE next cycle.
REQ-027 WRITE SHALL last exactly 1 cycle with mem_wea=1, mem_addra=word_ptr and mem_dina=the assembled word.
REQ-028 After WRITE: word_ptr+1, words_loaded+1, byte_idx=0, assembly register cleared.
REQ-029 After WRITE, the FSM SHALL go to FINISH if words_loaded reaches LOAD_WORDS, else to COLLECT.
REQ-030 The idle counter SHALL increment on each COLLECT cycle with no accepted byte.
REQ-031 When the idle counter reaches IDLE_TIMEOUT-1, the FSM SHALL go to FINISH and discard any partial word (byte_idx!=0), which is never written.
REQ-032 FINISH SHALL last 1 cycle with load_done=1 and cpu_hold=1, then return to RUN; the CPU therefore restarts from PC 0.
REQ-033 words_loaded SHALL hold its value in RUN until the next load_start.
REQ-034 mem_wea SHALL never be asserted in RUN, COLLECT or FINISH.
REQ-035 word_ptr SHALL not wrap: the LOAD_WORDS bound forces FINISH before address 16384.

Reset
REQ-036 reset SHALL take priority over all inputs, including a simultaneous load_start or rx_valid.
REQ-037 reset SHALL force RUN and set word_ptr=0, byte_idx=0, idle=0, words_loaded=0, rx_ready=0, mem_wea=0, load_done=0 and cpu_hold=0.
REQ-038 reset mid-session SHALL abort the session; words already written stay in RAM, and the partial word is lost.

Verification (LOAD_WORDS=4, IDLE_TIMEOUT=8)
REQ-039 Test: in RUN, cpu_addr=5 with RAM[5]=0x2402000A -> cpu_instr=0x2402000A one cycle later, cpu_hold=0.
REQ-040 Test: load_start, then bytes 0x0A,0x00,0x02,0x24 -> one mem_wea pulse at addr 0 with data 0x2402000A; words_loaded=1.
REQ-041 Test: 16 bytes streamed back-to-back -> writes at addr 0..3, then load_done pulse; words_loaded=4, cpu_hold falls the cycle after load_done, and further rx_valid is not accepted.
REQ-042 Test: 6 bytes then 8 idle cycles -> one write at addr 0, no write at addr 1, load_done pulse, words_loaded=1.
REQ-043 Test: reset asserted in COLLECT after 2 bytes -> RUN next cycle, cpu_hold=0, no write, words_loaded=0.
REQ-044 Test: load_start pulsed during COLLECT -> ignored; word_ptr and byte_idx are unchanged.
